// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, parity selectors, line idle level.
// Also used by the receive path, so keep encodings stable.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

  // Bit counter width; a one-bit payload still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/tx_serializer.sv
// Latched payload shift register plus bit counter for the UART transmitter.
// Load captures the word; each shift exposes the next bit, LSB first.
module tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_shift,
  output logic                  o_bit,
  output logic                  o_last
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;

  // The counter loads all-ones so the shift that puts bit 0 on the line
  // wraps it to 0; from then on it equals the index of the bit on the line.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '1;
    end else if (i_shift) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_bit  = r_shift[0];
  assign o_last = (r_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity (UART_TX_PARITY_EN), stop; one bit per CLK.
// Outputs registered, start bit appears the edge a request is accepted; requests while busy are dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  tx_state_e r_state;
  tx_state_e w_next;
  logic      w_load;
  logic      w_shift;
  logic      w_bit;
  logic      w_last;
  logic      w_tx_next;
  logic      r_tx;
  logic      r_busy;

  tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_load  (w_load),
    .i_data  (P_DATA),
    .i_shift (w_shift),
    .o_bit   (w_bit),
    .o_last  (w_last)
  );

`ifdef UART_TX_PARITY_EN
  logic r_par_en;
  logic r_par_typ;
  logic r_par_acc;
  logic w_parity;

  // Parity accumulates over the latched bits as they go out on the line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par_en  <= 1'b0;
      r_par_typ <= PAR_EVEN;
      r_par_acc <= 1'b0;
    end else if (w_load) begin
      r_par_en  <= PAR_EN;
      r_par_typ <= PAR_TYP;
      r_par_acc <= 1'b0;
    end else if (w_shift) begin
      r_par_acc <= r_par_acc ^ w_bit;
    end
  end

  assign w_parity = (r_par_typ == PAR_ODD) ? ~r_par_acc : r_par_acc;
`else
  logic w_unused;
  assign w_unused = PAR_EN ^ PAR_TYP;
`endif

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_tx_next = LINE_IDLE;
    case (r_state)
      TX_IDLE: begin
        if (Data_Valid) begin
          w_next = TX_START;
          w_load = 1'b1;
        end
      end
      TX_START: w_next = TX_DATA;
      TX_DATA: begin
        if (w_last) begin
`ifdef UART_TX_PARITY_EN
          w_next = r_par_en ? TX_PARITY : TX_STOP;
`else
          w_next = TX_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: w_next = TX_STOP;
`endif
      TX_STOP: w_next = TX_IDLE;
      default: w_next = TX_IDLE;
    endcase

    // Line value is chosen for the state being entered so it is registered in step.
    w_shift = (w_next == TX_DATA);
    case (w_next)
      TX_START:  w_tx_next = 1'b0;
      TX_DATA:   w_tx_next = w_bit;
`ifdef UART_TX_PARITY_EN
      TX_PARITY: w_tx_next = w_parity;
`endif
      default:   w_tx_next = LINE_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= TX_IDLE;
      r_tx    <= LINE_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_next != TX_IDLE);
    end
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected line bits are queued per request, a negedge monitor pops one per busy cycle.
module tb_uart_tx;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic  sb[$];
  string cur_name = "none";
  int    mon_idx  = 0;
  logic  mon_exp;

  // Frames written first-bit-on-line at the MSB end of the meaningful length.
`ifdef UART_TX_PARITY_EN
  localparam int         LEN_P   = 11;
  localparam logic [10:0] EXP_A5E = 11'b01010010101;
  localparam logic [10:0] EXP_A5O = 11'b01010010111;
  localparam logic [10:0] EXP_81  = 11'b01000000101;
  localparam logic [10:0] EXP_55  = 11'b01010101001;
  localparam logic [10:0] EXP_0F  = 11'b01111000011;
`else
  localparam int         LEN_P   = 10;
  localparam logic [10:0] EXP_A5E = 11'b00101001011;
  localparam logic [10:0] EXP_A5O = 11'b00101001011;
  localparam logic [10:0] EXP_81  = 11'b00100000011;
  localparam logic [10:0] EXP_55  = 11'b00101010101;
  localparam logic [10:0] EXP_0F  = 11'b00111100001;
`endif
  localparam logic [10:0] EXP_3C  = 11'b00001111001;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST && busy) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL %s extra_busy: busy=1 TX_OUT=%0b, required busy=0 (frame already complete)", cur_name, TX_OUT);
      end else begin
        mon_exp = sb.pop_front();
        if (TX_OUT !== mon_exp) begin
          n_errors++;
          $display("FAIL %s line_bit%0d: TX_OUT=%0b, required %0b", cur_name, mon_idx, TX_OUT, mon_exp);
        end
        mon_idx++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b, required %0b", name, act, exp);
    end
  endtask

  // Called just after a negedge; the request is sampled at the next posedge (T0).
  task automatic issue(input string name, input logic [7:0] d, input logic pe, input logic pt,
                       input logic [10:0] exp, input int len);
    cur_name = name;
    mon_idx  = 0;
    for (int i = len - 1; i >= 0; i--) sb.push_back(exp[i]);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    tick(1);
    Data_Valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < 40) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (k >= 40) begin
      n_errors++;
      $display("FAIL %s_done: busy=%0b pending_bits=%0d after %0d cycles, required busy=0 pending_bits=0",
               name, busy, sb.size(), k);
      sb.delete();
    end
    repeat (2) begin
      tick(1);
      chk({name, "_idle_tx"}, TX_OUT, 1'b1);
      chk({name, "_idle_busy"}, busy, 1'b0);
    end
  endtask

  initial begin
    RST        = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    tick(2);
    chk("reset_tx", TX_OUT, 1'b1);
    chk("reset_busy", busy, 1'b0);
    RST = 1'b1;
    tick(2);
    chk("idle_tx", TX_OUT, 1'b1);

    issue("a5_even", 8'hA5, 1'b1, 1'b0, EXP_A5E, LEN_P);
    wait_done("a5_even");

    issue("a5_odd", 8'hA5, 1'b1, 1'b1, EXP_A5O, LEN_P);
    wait_done("a5_odd");

    issue("3c_nopar", 8'h3C, 1'b0, 1'b1, EXP_3C, 10);
    wait_done("3c_nopar");

    // Requests at T0+3 and at the edge ending STOP must be dropped; live inputs change mid-frame.
    issue("x81", 8'h81, 1'b1, 1'b0, EXP_81, LEN_P);
    tick(2);
    P_DATA     = 8'hFF;
    PAR_TYP    = 1'b1;
    Data_Valid = 1'b1;
    tick(1);
    Data_Valid = 1'b0;
    tick(LEN_P - 4);
    Data_Valid = 1'b1;
    tick(1);
    Data_Valid = 1'b0;
    PAR_TYP    = 1'b0;
    wait_done("x81");

    // Mid-frame reset abandons the frame immediately.
    issue("x55", 8'h55, 1'b1, 1'b0, EXP_55, LEN_P);
    tick(4);
    #2 RST = 1'b0;
    #1;
    chk("midrst_tx", TX_OUT, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    sb.delete();
    tick(2);
    chk("inrst_tx", TX_OUT, 1'b1);
    RST = 1'b1;
    tick(1);

    issue("x0f_after_rst", 8'h0F, 1'b1, 1'b1, EXP_0F, LEN_P);
    wait_done("x0f_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
